prog_loader_tx: RTL and testbench

//  Transmit side of the OneBitProcessor serial program-load interface. Buffers
//  13-bit instructions written in parallel and shifts them MSB-first, one bit per
//  clk, onto ser_data while holding ser_en high. ser_data drives inReg[0] and
//  ser_en drives en. Loads back-to-back words into consecutive processor slots.

---
 rtl/prog_loader_tx.sv | 185 ++++++++++++++++++
 tb/tb_prog_loader_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader_tx.sv
// Serial program-load transmitter: queues INSTR_W-bit words and shifts them MSB-first
// on ser_data with ser_en high. Define PROG_LOADER_SLOTCHK_EN to cap a load at MEM_SLOTS words.
module prog_loader_tx #(
  parameter int unsigned INSTR_W   = 13,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned PTR_W     = 4,
  parameter int unsigned MEM_SLOTS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               go,
  input  logic               abort,
  output logic               ser_en,
  output logic               ser_data,
  output logic               busy,
  output logic               done,
  output logic [PTR_W:0]     level,
  output logic               ovf
);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(INSTR_W);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   cnt_q, cnt_d;
  logic [0:0]         state_q, state_d;
  logic [INSTR_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic               ser_en_q, ser_en_d, ser_data_q, ser_data_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               push, load, flush, level_nz;
  logic               slot_full_c, slot_last_c;
  logic [INSTR_W-1:0] head;

`ifdef PROG_LOADER_SLOTCHK_EN
  localparam int unsigned SLOT_W = $clog2(MEM_SLOTS + 1);
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              ovf_q, ovf_d;
  assign slot_full_c = (slot_q == SLOT_W'(MEM_SLOTS));
  assign slot_last_c = (slot_q == SLOT_W'(MEM_SLOTS - 1));
  assign ovf         = ovf_q;
`else
  logic unused_mem_slots;
  assign unused_mem_slots = ^MEM_SLOTS;
  assign slot_full_c = 1'b0;
  assign slot_last_c = 1'b0;
  assign ovf         = 1'b0;
`endif

  assign level    = cnt_q;
  assign wr_ready = (cnt_q != LVL_W'(DEPTH));
  assign level_nz = (cnt_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign push     = wr_valid & wr_ready & ~abort;

  // Sequencer: abort wins, otherwise load words at go or at each word boundary
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    ser_en_d   = ser_en_q;
    ser_data_d = ser_data_q;
    done_d     = 1'b0;
    load       = 1'b0;
    flush      = 1'b0;
`ifdef PROG_LOADER_SLOTCHK_EN
    slot_d     = slot_q;
    ovf_d      = ovf_q;
`endif
    if (abort) begin
      flush      = 1'b1;
      state_d    = S_IDLE;
      ser_en_d   = 1'b0;
      ser_data_d = 1'b0;
      bitcnt_d   = '0;
      shreg_d    = '0;
`ifdef PROG_LOADER_SLOTCHK_EN
      slot_d     = '0;
      ovf_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go && level_nz && !slot_full_c) load = 1'b1;
`ifdef PROG_LOADER_SLOTCHK_EN
          if (go && level_nz && slot_full_c) ovf_d = 1'b1;
`endif
        end
        default: begin
          if (bitcnt_q != '0) begin
            ser_data_d = shreg_q[INSTR_W-1];
            shreg_d    = {shreg_q[INSTR_W-2:0], 1'b0};
            bitcnt_d   = bitcnt_q - CNT_W'(1);
          end else begin
`ifdef PROG_LOADER_SLOTCHK_EN
            slot_d = slot_q + SLOT_W'(1);
            if (slot_last_c && level_nz) ovf_d = 1'b1;
`endif
            if (level_nz && !slot_last_c) begin
              load = 1'b1;
            end else begin
              state_d    = S_IDLE;
              ser_en_d   = 1'b0;
              ser_data_d = 1'b0;
              done_d     = 1'b1;
            end
          end
        end
      endcase
    end
    // Head word: present its MSB now, keep the rest left-aligned
    if (load) begin
      state_d    = S_SHIFT;
      ser_en_d   = 1'b1;
      ser_data_d = head[INSTR_W-1];
      shreg_d    = {head[INSTR_W-2:0], 1'b0};
      bitcnt_d   = CNT_W'(INSTR_W - 1);
    end
    busy_d = (state_d == S_SHIFT);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (load) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + LVL_W'(push) - LVL_W'(load);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      ser_en_q   <= 1'b0;
      ser_data_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef PROG_LOADER_SLOTCHK_EN
      slot_q     <= '0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      ser_en_q   <= ser_en_d;
      ser_data_q <= ser_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef PROG_LOADER_SLOTCHK_EN
      slot_q     <= slot_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign ser_en   = ser_en_q;
  assign ser_data = ser_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_prog_loader_tx.sv
// Directed bench for prog_loader_tx: captures the serial stream into a model of the
// processor's slot memory and compares against hand-computed words and timing.
module tb_prog_loader_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [12:0] wr_data = '0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic        ser_en, ser_data, busy, done, ovf;
  logic [4:0]  level;

  int n_checks = 0;
  int n_err = 0;

  // stream capture results
  int          en_cnt, first_en, last_en, done_cnt, done_at, nslots, bitpos;
  logic [12:0] acc;
  logic [12:0] slots [32];
  logic [12:0] words [16];

  prog_loader_tx dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .go(go), .abort(abort), .ser_en(ser_en),
    .ser_data(ser_data), .busy(busy), .done(done), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the next negedge
  task automatic put(input logic [12:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  // Pulse go, then sample once per cycle; optionally write late_word at cycle late_cyc
  task automatic run_stream(input int budget, input int late_cyc, input logic [12:0] late_word);
    en_cnt = 0; first_en = 0; last_en = 0; done_cnt = 0; done_at = 0;
    nslots = 0; bitpos = 0; acc = '0;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (c == late_cyc) begin
        wr_valid = 1'b1;
        wr_data  = late_word;
      end else if (c == late_cyc + 1) begin
        wr_valid = 1'b0;
      end
      if (ser_en) begin
        en_cnt++;
        if (first_en == 0) first_en = c;
        last_en = c;
        acc = {acc[11:0], ser_data};
        bitpos++;
        if (bitpos == 13) begin
          if (nslots < 32) slots[nslots] = acc;
          nslots++;
          bitpos = 0;
        end
      end
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (done_cnt != 0 && c > done_at + 2) break;
      @(negedge clk);
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    int bad;
    int abort_en, abort_done;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ser_en", ser_en, 0);
    check("rst_ser_data", ser_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_level", level, 0);
    check("rst_wr_ready", wr_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // go while empty is ignored
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("go_empty_busy", busy, 0);
    check("go_empty_en", ser_en, 0);

    // single all-ones word
    put(13'h1FFF);
    check("one_level", level, 1);
    run_stream(40, 0, '0);
    check("one_en_cnt", en_cnt, 13);
    check("one_first", first_en, 1);
    check("one_contig", last_en - first_en + 1, 13);
    check("one_word", slots[0], 13'h1FFF);
    check("one_done_cnt", done_cnt, 1);
    check("one_done_at", done_at, 14);
    check("one_idle_en", ser_en, 0);
    check("one_idle_busy", busy, 0);

    // two alternating words back-to-back
    put(13'h1555);
    put(13'h0AAA);
    check("two_level", level, 2);
    run_stream(60, 0, '0);
    check("two_en_cnt", en_cnt, 26);
    check("two_contig", last_en - first_en + 1, 26);
    check("two_slot0", slots[0], 13'h1555);
    check("two_slot1", slots[1], 13'h0AAA);
    check("two_done_at", done_at, 27);

    // a word written mid-stream is appended without a gap
    put(13'h1234);
    run_stream(60, 4, 13'h0F0F);
    check("late_en_cnt", en_cnt, 26);
    check("late_contig", last_en - first_en + 1, 26);
    check("late_slot0", slots[0], 13'h1234);
    check("late_slot1", slots[1], 13'h0F0F);
    check("late_done_cnt", done_cnt, 1);

    pulse_abort();
    check("idle_abort_level", level, 0);

    // fill the FIFO; 17th write is dropped
    for (int i = 0; i < 16; i++) begin
      words[i] = 13'((i * 397 + 5) % 8192);
      put(words[i]);
    end
    check("full_level", level, 16);
    check("full_wr_ready", wr_ready, 0);
    put(13'h1ABC);
    check("full_drop_level", level, 16);
    run_stream(260, 0, '0);
    check("full_en_cnt", en_cnt, 208);
    check("full_contig", last_en - first_en + 1, 208);
    check("full_nslots", nslots, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (slots[i] !== words[i]) bad++;
    check("full_slot_data", bad, 0);
    check("full_done_at", done_at, 209);
    check("full_ovf", ovf, 0);
    check("full_level_end", level, 0);

    // abort while the 5th bit of a 3-word stream is on the line
    put(13'h1111);
    put(13'h0222);
    put(13'h0333);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (4) @(negedge clk);
    check("ab_pre_en", ser_en, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ab_en", ser_en, 0);
    check("ab_data", ser_data, 0);
    check("ab_level", level, 0);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    abort_en = 0;
    abort_done = 0;
    for (int c = 0; c < 20; c++) begin
      if (ser_en) abort_en++;
      if (done) abort_done++;
      @(negedge clk);
    end
    check("ab_quiet_en", abort_en, 0);
    check("ab_quiet_done", abort_done, 0);

    // asynchronous reset mid-word, observed before any clock edge
    put(13'h1FFF);
    put(13'h1FFF);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_pre_en", ser_en, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_en", ser_en, 0);
    check("mid_rst_data", ser_data, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_wr_ready", wr_ready, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef PROG_LOADER_SLOTCHK_EN
    // 17 words queued against 16 slots: the 17th stays and flags overflow
    for (int i = 0; i < 16; i++) put(words[i]);
    run_stream(260, 3, 13'h1EEE);
    check("slot_en_cnt", en_cnt, 208);
    check("slot_nslots", nslots, 16);
    check("slot_en_off", ser_en, 0);
    check("slot_ovf", ovf, 1);
    check("slot_level", level, 1);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    check("slot_go_ignored", busy, 0);
    check("slot_ovf_sticky", ovf, 1);
    pulse_abort();
    check("slot_abort_ovf", ovf, 0);
`else
    for (int i = 0; i < 16; i++) put(words[i]);
    put(13'h1EEE);
    run_stream(260, 0, '0);
    check("noslot_en_cnt", en_cnt, 208);
    check("noslot_ovf", ovf, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
